// File: rtl/hex_msg_pkg.sv
// Shared types and constants for the hex message scroller.
package hex_msg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam int NIBBLE_W = 4;
  localparam int DIGITS   = 4;

  localparam logic [DIGITS-1:0]          BLANK_ALL  = 4'hF;
  localparam logic [NIBBLE_W*DIGITS-1:0] DISP_RESET = 16'h0000;
endpackage

// File: rtl/hex_msg_scroller_step_tick_gen.sv
// Step prescaler: counts enabled cycles and strobes tick on the last one of each period.
module step_tick_gen #(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             at_max;

  assign at_max = (cnt_reg == CNT_W'(STEP_CYCLES - 1));
  assign tick   = en && at_max && !rst && !restart;

  // The count holds while en is low so a paused scroll resumes mid-period.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= at_max ? '0 : cnt_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/hex_msg_scroller.sv
// Buffers a nibble message and scrolls a 4-digit window through it for the 7-seg driver.
module hex_msg_scroller
  import hex_msg_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 25_000_000,
  localparam int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_valid,
  input  logic [NIBBLE_W-1:0]          wr_data,
  input  logic                         wr_last,
  output logic                         wr_ready,
  input  logic                         run,
  input  logic                         dir,
  output logic [NIBBLE_W*DIGITS-1:0]   display,
  output logic [DIGITS-1:0]            blank_mask,
  output logic                         step_pulse,
  output logic [LEN_W-1:0]             msg_len
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SUM_W = LEN_W + 1;

  state_t               state_reg, state_next;
  logic [LEN_W-1:0]     count_reg, count_next;
  logic [LEN_W-1:0]     msg_len_reg, msg_len_next;
  logic [IDX_W-1:0]     pos_reg, pos_next;
  logic [NIBBLE_W-1:0]  mem [DEPTH];

  logic in_run, xfer, last, tick;

  assign in_run     = (state_reg == RUN);
  assign wr_ready   = !rst && !clear && !in_run;
  assign xfer       = wr_valid && wr_ready;
  assign last       = wr_last || (count_reg == LEN_W'(DEPTH - 1));
  assign step_pulse = tick;
  assign msg_len    = msg_len_reg;

  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[count_reg[IDX_W-1:0]] <= wr_data;
    end
  end

  step_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_step_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (in_run && run),
    .restart (clear || !in_run),
    .tick    (tick)
  );

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    msg_len_next = msg_len_reg;
    pos_next     = pos_reg;
    case (state_reg)
      IDLE, LOAD: begin
        if (xfer) begin
          count_next = count_reg + LEN_W'(1);
          if (last) begin
            state_next   = RUN;
            msg_len_next = count_reg + LEN_W'(1);
            pos_next     = '0;
          end else begin
            state_next = LOAD;
          end
        end
      end
      RUN: begin
        if (tick) begin
          if (!dir) begin
            pos_next = (LEN_W'(pos_reg) == msg_len_reg - LEN_W'(1)) ? '0 : pos_reg + IDX_W'(1);
          end else begin
            pos_next = (pos_reg == '0) ? IDX_W'(msg_len_reg - LEN_W'(1)) : pos_reg - IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next   = IDLE;
      count_next   = '0;
      msg_len_next = '0;
      pos_next     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      msg_len_reg <= '0;
      pos_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      msg_len_reg <= msg_len_next;
      pos_reg     <= pos_next;
    end
  end

  logic [NIBBLE_W*DIGITS-1:0] disp_win;
  logic [DIGITS-1:0]          mask_win;

  // pos < msg_len and offset <= 3, so a single conditional subtract implements the modulo
  // for every unblanked digit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [SUM_W-1:0] len_ext, sum;
    logic [IDX_W-1:0] idx;

    assign len_ext = SUM_W'(msg_len_reg);
    assign sum     = SUM_W'(pos_reg) + SUM_W'(gi);
    assign idx     = IDX_W'((sum >= len_ext) ? sum - len_ext : sum);
    assign mask_win[DIGITS-1-gi] = (SUM_W'(gi) >= len_ext);
    assign disp_win[(DIGITS-1-gi)*NIBBLE_W +: NIBBLE_W] =
      mask_win[DIGITS-1-gi] ? '0 : mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst || clear || !in_run) begin
      display    <= DISP_RESET;
      blank_mask <= BLANK_ALL;
    end else begin
      display    <= disp_win;
      blank_mask <= mask_win;
    end
  end
endmodule

// File: tb/tb_hex_msg_scroller.sv
// Randomized scoreboard bench for hex_msg_scroller against a queue-based message model.
module tb_hex_msg_scroller;
  localparam int DEPTH = 16;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        rst, clear, wr_valid, wr_last, run, dir;
  logic [3:0]  wr_data;
  logic        wr_ready, step_pulse;
  logic [15:0] display;
  logic [3:0]  blank_mask;
  logic [4:0]  msg_len;

  hex_msg_scroller #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .run        (run),
    .dir        (dir),
    .display    (display),
    .blank_mask (blank_mask),
    .step_pulse (step_pulse),
    .msg_len    (msg_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message contents, window position, enabled-cycle count since RUN entry.
  logic [3:0]  msg [$];
  logic [19:0] exp_q [$];
  logic [3:0]  msg_in [DEPTH];
  bit          running = 0;
  int          pos = 0;
  int          active = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [19:0] model_window();
    logic [15:0] d;
    logic [3:0]  m;
    int          len;
    d = '0;
    m = '0;
    len = msg.size();
    for (int k = 0; k < 4; k++) begin
      if (k < len) d[(3-k)*4 +: 4] = msg[(pos + k) % len];
      else         m[3-k] = 1'b1;
    end
    return {m, d};
  endfunction

  function automatic void model_edge();
    if (rst || clear) begin
      msg.delete();
      running = 0;
      pos = 0;
      active = 0;
    end else if (!running) begin
      if (wr_valid) begin
        msg.push_back(wr_data);
        if (wr_last || msg.size() == DEPTH) begin
          running = 1;
          pos = 0;
          active = 0;
        end
      end
    end else if (run) begin
      active++;
      if (active % STEP == 0) begin
        if (!dir) pos = (pos + 1) % msg.size();
        else      pos = (pos + msg.size() - 1) % msg.size();
        exp_q.push_back(model_window());
      end
    end
  endfunction

  // One clock cycle with the inputs currently driven.
  task automatic cyc();
    #2;
    chk("wr_ready", 32'(wr_ready), 32'(!rst && !clear && !running));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_msg(input int len, input bit use_last);
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1;
      wr_data  = msg_in[i];
      wr_last  = use_last && (i == len - 1);
      cyc();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic check_first_window(input string name);
    run = 1'b1;
    cyc();
    cyc();
    chk({name, "_disp"}, 32'(display), 32'(model_window() & 20'h0FFFF));
    chk({name, "_mask"}, 32'(blank_mask), 32'(model_window() >> 16));
    chk({name, "_len"}, 32'(msg_len), 32'(msg.size()));
  endtask

  task automatic pause_and_clear(input bit with_write);
    logic [15:0] snap;
    run = 1'b0;
    cyc(); cyc(); cyc();
    snap = display;
    for (int i = 0; i < 7; i++) cyc();
    chk("pause_frozen", 32'(display), 32'(snap));
    clear    = 1'b1;
    wr_valid = with_write;
    wr_data  = 4'(($urandom));
    cyc();
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk("clear_disp", 32'(display), 32'h0000);
    chk("clear_mask", 32'(blank_mask), 32'hF);
    chk("clear_len", 32'(msg_len), 32'd0);
  endtask

  // Monitor: the window produced by a step appears two samples after the pulse.
  initial begin
    bit p1 = 0, p2 = 0;
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (p2) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_step: got display %h with no step predicted", display);
        end else begin
          e = exp_q.pop_front();
          $display("step: display=%h mask=%h expected %h/%h", display, blank_mask, e[15:0], e[19:16]);
          chk("step_disp", 32'(display), 32'(e[15:0]));
          chk("step_mask", 32'(blank_mask), 32'(e[19:16]));
        end
      end
      p2 = p1;
      p1 = (step_pulse === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    run = 1'b0; dir = 1'b0;

    // Reset and idle
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_disp", 32'(display), 32'h0000);
    chk("rst_mask", 32'(blank_mask), 32'hF);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("idle_disp", 32'(display), 32'h0000);
    chk("idle_mask", 32'(blank_mask), 32'hF);
    chk("idle_len", 32'(msg_len), 32'd0);

    // Five-nibble message scrolling left
    for (int i = 0; i < 5; i++) msg_in[i] = 4'(i + 1);
    load_msg(5, 1'b1);
    dir = 1'b0;
    check_first_window("five");
    chk("five_const", 32'(display), 32'h1234);
    for (int i = 0; i < 24; i++) cyc();
    run = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    run = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    pause_and_clear(1'b1);

    // Two-nibble message scrolling right
    msg_in[0] = 4'hA; msg_in[1] = 4'hB;
    load_msg(2, 1'b1);
    dir = 1'b1;
    check_first_window("two");
    chk("two_const", 32'(display), 32'hAB00);
    chk("two_mask", 32'(blank_mask), 32'h3);
    for (int i = 0; i < 14; i++) cyc();
    pause_and_clear(1'b0);

    // Full buffer without wr_last, then a rejected extra write
    for (int i = 0; i < DEPTH; i++) msg_in[i] = 4'(i);
    load_msg(DEPTH, 1'b0);
    chk("full_len", 32'(msg_len), 32'd16);
    wr_valid = 1'b1; wr_data = 4'h9;
    cyc();
    wr_valid = 1'b0;
    dir = 1'b0;
    check_first_window("full");
    chk("full_const", 32'(display), 32'h0123);
    for (int i = 0; i < 12; i++) cyc();
    pause_and_clear(1'b1);

    // Clear colliding with a write during LOAD
    for (int i = 0; i < 3; i++) msg_in[i] = 4'hC;
    load_msg(3, 1'b0);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 4'hE;
    cyc();
    clear = 1'b0; wr_valid = 1'b0;
    chk("loadclr_len", 32'(msg_len), 32'd0);
    chk("loadclr_disp", 32'(display), 32'h0000);

    // Randomized messages, directions and pauses
    for (int t = 0; t < 12; t++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) msg_in[i] = 4'($urandom);
      load_msg(len, (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
      dir = 1'($urandom_range(0, 1));
      check_first_window("rand");
      for (int i = 0; i < 40; i++) begin
        run = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) dir = ~dir;
        cyc();
      end
      pause_and_clear(1'($urandom_range(0, 1)));
    end

    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("steps_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
